// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared opcode constants, predecode flags and slot helpers for the fetch stage
// Contents:
//   OP_J, RET_CODE   slot-0 control-transfer encodings
//   IMEM_TAG         store-address tag that selects instruction memory
//   pdec_t           predecode result {jabs, call, ret}
//   slot_of()        extract slot k (k=0 is the MSB slot) from a bundle
//   predecode()      classify the low six bits of slot 0
package ifetch_pkg;

  localparam logic [2:0] OP_J     = 3'b111;
  localparam logic [5:0] RET_CODE = 6'b100111;
  localparam logic [4:0] IMEM_TAG = 5'b11110;

  // Widest bundle/slot the helper accepts; callers zero-extend into it.
  localparam int MAX_BW = 1024;
  localparam int MAX_SW = 64;

  typedef struct packed {
    logic jabs;
    logic call;
    logic ret;
  } pdec_t;

  function automatic logic [MAX_SW-1:0] slot_of(input logic [MAX_BW-1:0] bundle,
                                                input int slots, input int sw, input int k);
    logic [MAX_BW-1:0] sh;
    logic [MAX_SW-1:0] mask;
    sh   = bundle >> ((slots - 1 - k) * sw);
    mask = (MAX_SW'(1) << sw) - MAX_SW'(1);
    return sh[MAX_SW-1:0] & mask;
  endfunction

  // fn = lo[5:3]; jabs needs {fn[2],fn[0]}=00, call needs fn[2:1]=01.
  function automatic pdec_t predecode(input logic [5:0] lo);
    pdec_t p;
    p.jabs = (lo[2:0] == OP_J) && !lo[5] && !lo[3];
    p.call = (lo[2:0] == OP_J) && (lo[5:4] == 2'b01);
    p.ret  = (lo == RET_CODE);
    return p;
  endfunction

endpackage

// File: rtl/ifetch_ras.sv
// rtl/ifetch_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
// Ports:
//   clk, rst_n   clock, async active-low reset (clears pointer and count only)
//   push, pop    push din / discard top (pop ignored when empty, push wins if both)
//   din          address to push
//   top          most recently pushed entry (meaningless when empty)
//   empty, full  occupancy flags
module ifetch_ras #(
  parameter int DEPTH = 8,
  parameter int W     = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  stack [DEPTH];
  logic [PW-1:0] ptr;      // next slot to write; wraps, so a full push lands on the oldest
  logic [PW:0]   count;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign top   = stack[ptr - PW'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack[ptr] <= din;
  end

endmodule

// File: rtl/ifetch_vliw.sv
// rtl/ifetch_vliw.sv - VLIW fetch stage: PC, bundle BRAM, slot-0 predecode, return stack, store patch port
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   stall, flush                hold everything / squash the output bundle (flush wins)
//   npc, npc_en                 redirect from later stages
//   inst, inst_pc, inst_valid   fetched bundle (slot 0 in the MSBs), its address, valid flag
//   ras_empty                   return-address stack holds nothing
//   dec_op32, daddr3, dec_mwe3  one-slot store into instruction memory
module ifetch_vliw #(
  parameter int         SLOTS     = 4,
  parameter int         SLOT_W    = 32,
  parameter int         ADDR_W    = 14,
  parameter int         RAS_DEPTH = 8,
  parameter logic [4:0] IMEM_TAG  = ifetch_pkg::IMEM_TAG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       npc,
  input  logic                    npc_en,
  output logic [SLOTS*SLOT_W-1:0] inst,
  output logic [ADDR_W-1:0]       inst_pc,
  output logic                    inst_valid,
  output logic                    ras_empty,
  input  logic [SLOT_W-1:0]       dec_op32,
  input  logic [29:0]             daddr3,
  input  logic                    dec_mwe3
);
  import ifetch_pkg::*;

  localparam int SO    = $clog2(SLOTS);
  localparam int DEPTH = 1 << ADDR_W;

  // Packed slot dimension gives each slot its own write lane.
  logic [SLOTS-1:0][SLOT_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] faddr;
  logic [ADDR_W-1:0] ras_top;
  logic [SLOT_W-1:0] s0;
  pdec_t             pd;
  logic              run;
  logic              ras_push;
  logic              ras_pop;
  logic              ras_full;
  logic              we;
  logic [ADDR_W-1:0] wrow;
  logic [SO-1:0]     wslot;
  logic              unused_bits;

  assign s0  = SLOT_W'(slot_of(MAX_BW'(inst), SLOTS, SLOT_W, 0));
  assign pd  = inst_valid ? predecode(s0[5:0]) : '0;
  assign run = !flush && !stall;

  // A redirect squashes whatever control transfer sits in the current bundle,
  // including its stack side effect.
  assign ras_push = run && !npc_en && pd.call;
  assign ras_pop  = run && !npc_en && pd.ret && !ras_empty;

  always_comb begin
    faddr = pc;
    if (npc_en)                      faddr = npc;
    else if (pd.jabs)                faddr = s0[6 +: ADDR_W];
    else if (pd.ret && !ras_empty)   faddr = ras_top;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else if (flush) begin
      inst       <= '0;
      inst_valid <= 1'b0;
      if (npc_en) pc <= npc;
    end else if (!stall) begin
      inst       <= mem[faddr];
      inst_pc    <= faddr;
      inst_valid <= 1'b1;
      pc         <= faddr + ADDR_W'(1);
    end
  end

  ifetch_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign we    = dec_mwe3 && (daddr3[29:25] == IMEM_TAG);
  assign wrow  = daddr3[SO +: ADDR_W];
  assign wslot = daddr3[SO-1:0];

  // Slot k lives in packed lane SLOTS-1-k, which is ~k for a power-of-two slot count.
  // Reads are non-blocking in the other process, so a same-row read sees old data.
  always_ff @(posedge clk) begin
    if (we) mem[wrow][~wslot] <= dec_op32;
  end

  assign unused_bits = ^{daddr3, s0, ras_full};

endmodule

// File: tb/tb_ifetch_vliw.sv
// tb/tb_ifetch_vliw.sv - self-checking bench for ifetch_vliw
module tb_ifetch_vliw;

  localparam int SLOTS     = 4;
  localparam int SLOT_W    = 32;
  localparam int ADDR_W    = 14;
  localparam int RAS_DEPTH = 8;
  localparam int BW        = SLOTS * SLOT_W;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam logic [4:0] TAG = 5'b11110;
  localparam int FILL      = 'h400;
  localparam int RLIM      = 'h1e0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] npc = '0;
  logic              npc_en = 1'b0;
  logic [BW-1:0]     inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              ras_empty;
  logic [SLOT_W-1:0] dec_op32 = '0;
  logic [29:0]       daddr3 = '0;
  logic              dec_mwe3 = 1'b0;

  always #5 clk = ~clk;

  ifetch_vliw dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .npc        (npc),
    .npc_en     (npc_en),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .ras_empty  (ras_empty),
    .dec_op32   (dec_op32),
    .daddr3     (daddr3),
    .dec_mwe3   (dec_mwe3)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [BW-1:0] mem_m [DEPTH];
  logic [BW-1:0] m_inst;
  int            m_pc;
  int            m_inst_pc;
  bit            m_valid;
  int            ras[$];

  typedef struct {
    bit st; bit fl; bit ne; int np;
    int epc; bit ev; bit ee;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] waddr(input int row, input int slot);
    return {TAG, 9'b0, ADDR_W'(row), 2'(slot)};
  endfunction

  function automatic logic [31:0] enc_jabs(input int t);
    return (32'(t) << 6) | 32'h07;
  endfunction

  function automatic logic [31:0] enc_callj(input int t);
    return (32'(t) << 6) | 32'h17;
  endfunction

  localparam logic [31:0] ENC_RET = 32'h27;

  function automatic logic [31:0] rand_ctl();
    logic [31:0] hi;
    int k, t;
    logic [2:0] fn;
    hi = $urandom;
    k  = $urandom_range(0, 5);
    t  = $urandom_range(0, RLIM - 1);
    case (k)
      0: return {hi[31:3], 3'($urandom_range(0, 6))};
      1: return {hi[31:20], ADDR_W'(t), 3'b000, 3'b111};
      2: return {hi[31:20], ADDR_W'(t), 3'b010, 3'b111};
      3: return {hi[31:6], 3'b011, 3'b111};
      4: return {hi[31:6], 6'b100111};
      default: begin
        case ($urandom_range(0, 3))
          0: fn = 3'd1;
          1: fn = 3'd5;
          2: fn = 3'd6;
          default: fn = 3'd7;
        endcase
        return {hi[31:6], fn, 3'b111};
      end
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0; m_inst = '0; m_inst_pc = 0; m_valid = 0;
    ras.delete();
  endtask

  // Drive one cycle of inputs, advance the model, clock, and compare.
  task automatic step(input bit st, input bit fl, input bit ne, input int np,
                      input bit we, input logic [29:0] wa, input logic [31:0] wd, input bit chk);
    logic [31:0] s0;
    int op, fn, tgt, a, row, sl;
    bit jabs, call, ret;
    stall = st; flush = fl; npc_en = ne; npc = ADDR_W'(np);
    dec_mwe3 = we; daddr3 = wa; dec_op32 = wd;
    if (!rst_n) begin
      model_reset();
    end else if (fl) begin
      m_inst = '0; m_valid = 0;
      if (ne) m_pc = np;
    end else if (!st) begin
      s0   = m_valid ? m_inst[BW-1 -: SLOT_W] : 32'h0;
      op   = int'(s0 % 8);
      fn   = int'((s0 / 8) % 8);
      tgt  = int'((s0 / 64) % DEPTH);
      jabs = (op == 7) && (fn == 0 || fn == 2);
      call = (op == 7) && (fn == 2 || fn == 3);
      ret  = (s0 % 64) == 39;
      if (ne)                         a = np;
      else if (jabs)                  a = tgt;
      else if (ret && ras.size() > 0) a = ras[$];
      else                            a = m_pc;
      if (!ne && call) begin
        ras.push_back(m_pc);
        if (ras.size() > RAS_DEPTH) void'(ras.pop_front());
      end
      if (!ne && ret && ras.size() > 0) void'(ras.pop_back());
      m_inst = mem_m[a]; m_inst_pc = a; m_valid = 1; m_pc = (a + 1) % DEPTH;
    end
    if (we && wa[29:25] == TAG) begin
      row = int'(wa[15:2]);
      sl  = int'(wa[1:0]);
      mem_m[row][BW-1-sl*SLOT_W -: SLOT_W] = wd;
    end
    @(posedge clk);
    #1;
    if (chk) begin
      check("inst_valid", inst_valid, m_valid);
      check("inst", inst, m_inst);
      if (m_valid) check("inst_pc", inst_pc, m_inst_pc);
      check("ras_empty", ras_empty, ras.size() == 0);
    end
  endtask

  task automatic load(input int row, input int slot, input logic [31:0] d);
    step(0, 0, 0, 0, 1, waddr(row, slot), d, 0);
  endtask

  task automatic add(input bit st, input bit fl, input bit ne, input int np,
                     input int epc, input bit ev, input bit ee);
    tbl.push_back('{st, fl, ne, np, epc, ev, ee});
  endtask

  initial begin
    logic [BW-1:0] old;
    bit st, fl, ne, we;
    int np, row, slot;
    logic [4:0] tag;
    logic [31:0] wd;

    // Preload while held in reset; the write port ignores reset.
    for (int r = 0; r < FILL; r++)
      for (int s = 0; s < SLOTS; s++)
        load(r, s, (s == 0) ? 32'h0 : $urandom);
    for (int s = 0; s < SLOTS; s++) load(DEPTH - 1, s, (s == 0) ? 32'h0 : $urandom);
    load('h005, 0, enc_jabs('h040));
    load('h00a, 0, enc_callj('h100));
    load('h100, 0, ENC_RET);
    for (int i = 0; i < 8; i++) begin
      load('h300 + 16 * i, 0, enc_callj('h310 + 16 * i));
      load('h301 + 16 * i, 0, ENC_RET);
    end
    load('h380, 0, ENC_RET);

    check("rst_inst", inst, '0);
    check("rst_inst_pc", inst_pc, '0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_ras_empty", ras_empty, 1'b1);

    rst_n = 1'b1;

    //   st fl ne npc      exp_pc valid empty
    add(0, 0, 0, 0,       'h000, 1, 1);
    add(0, 0, 0, 0,       'h001, 1, 1);
    add(0, 0, 0, 0,       'h002, 1, 1);
    add(0, 0, 0, 0,       'h003, 1, 1);
    add(0, 0, 0, 0,       'h004, 1, 1);
    add(0, 0, 0, 0,       'h005, 1, 1);
    add(0, 0, 0, 0,       'h040, 1, 1);
    add(0, 0, 0, 0,       'h041, 1, 1);
    add(0, 0, 1, 'h00a,   'h00a, 1, 1);
    add(0, 0, 0, 0,       'h100, 1, 0);
    add(0, 0, 0, 0,       'h00b, 1, 1);
    add(0, 0, 0, 0,       'h00c, 1, 1);
    add(0, 0, 1, 'h005,   'h005, 1, 1);
    add(0, 0, 1, 'h200,   'h200, 1, 1);
    add(0, 0, 0, 0,       'h201, 1, 1);
    add(1, 0, 0, 0,       'h201, 1, 1);
    add(1, 0, 1, 'h123,   'h201, 1, 1);
    add(1, 0, 0, 0,       'h201, 1, 1);
    add(1, 1, 1, 'h030,   0,     0, 1);
    add(0, 0, 0, 0,       'h030, 1, 1);
    add(0, 0, 0, 0,       'h031, 1, 1);
    add(0, 0, 1, 'h00a,   'h00a, 1, 1);
    add(0, 0, 1, 'h200,   'h200, 1, 1);
    add(0, 0, 0, 0,       'h201, 1, 1);
    add(0, 0, 1, 'h3fff,  'h3fff, 1, 1);
    add(0, 0, 0, 0,       'h000, 1, 1);
    add(0, 0, 0, 0,       'h001, 1, 1);
    add(0, 1, 0, 0,       0,     0, 1);
    add(0, 0, 0, 0,       'h002, 1, 1);
    add(0, 0, 1, 'h00a,   'h00a, 1, 1);
    add(1, 0, 0, 0,       'h00a, 1, 1);
    add(0, 0, 0, 0,       'h100, 1, 0);
    add(0, 0, 0, 0,       'h00b, 1, 1);
    add(0, 0, 1, 'h00a,   'h00a, 1, 1);
    add(0, 1, 0, 0,       0,     0, 1);
    add(0, 0, 0, 0,       'h00b, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].st, tbl[i].fl, tbl[i].ne, tbl[i].np, 0, '0, '0, 1);
      check($sformatf("vec%0d_valid", i), inst_valid, tbl[i].ev);
      if (tbl[i].ev) check($sformatf("vec%0d_pc", i), inst_pc, tbl[i].epc);
      check($sformatf("vec%0d_empty", i), ras_empty, tbl[i].ee);
    end

    // Eight nested calls, then nine returns; the last one finds the stack empty.
    step(0, 0, 1, 'h300, 0, '0, '0, 1);
    check("nest_entry", inst_pc, 'h300);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, '0, '0, 1);
      check($sformatf("nest_call%0d", i), inst_pc, 'h310 + 16 * i);
      check($sformatf("nest_call%0d_empty", i), ras_empty, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, '0, '0, 1);
      check($sformatf("nest_ret%0d", i), inst_pc, 'h371 - 16 * i);
      check($sformatf("nest_ret%0d_empty", i), ras_empty, i == 7);
    end
    step(0, 0, 0, 0, 0, '0, '0, 1);
    check("nest_ret_fallthrough", inst_pc, 'h302);
    check("nest_final_empty", ras_empty, 1'b1);

    // Store into the row being fetched in the same cycle.
    old = mem_m[7];
    step(0, 0, 1, 7, 1, waddr(7, 2), 32'hDEADBEEF, 1);
    check("store_read_first", inst, old);
    step(0, 0, 1, 7, 1, {5'b00000, 9'b0, 14'd7, 2'd0}, 32'h12345678, 1);
    check("store_slot2", inst[63:32], 32'hDEADBEEF);
    check("store_other_slots", {inst[127:64], inst[31:0]}, {old[127:64], old[31:0]});
    step(0, 0, 1, 7, 0, '0, '0, 1);
    check("store_wrong_tag", inst[127:96], old[127:96]);

    // Random traffic against the model; fetch stays below RLIM by forced redirects.
    for (int c = 0; c < 1500; c++) begin
      st = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 19) == 0);
      ne = ($urandom_range(0, 9) == 0);
      np = $urandom_range(0, RLIM - 1);
      if (m_pc >= RLIM) ne = 1;
      we   = ($urandom_range(0, 2) == 0);
      row  = $urandom_range(0, 'h1ff);
      slot = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
      tag  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 29)) : TAG;
      wd   = (slot == 0) ? rand_ctl() : $urandom;
      step(st, fl, ne, np, we, {tag, 9'b0, ADDR_W'(row), 2'(slot)}, wd, 1);
    end

    // Asynchronous reset mid-cycle with a non-empty stack.
    step(0, 0, 1, 'h300, 0, '0, '0, 1);
    step(0, 0, 0, 0, 0, '0, '0, 1);
    check("pre_areset_nonempty", ras_empty, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_inst", inst, '0);
    check("areset_inst_pc", inst_pc, '0);
    check("areset_valid", inst_valid, 1'b0);
    check("areset_ras_empty", ras_empty, 1'b1);
    model_reset();
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, '0, '0, 1);
    check("after_areset_pc", inst_pc, 'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_vliw.md
Name: ifetch_vliw

Overview:
- Parametrised VLIW instruction-fetch stage: holds the fetch PC, reads one bundle per cycle from on-chip instruction BRAM, and predecodes slot 0 for absolute jumps, calls and returns.
- Integrated circular return-address stack; external redirect and flush from later stages.
- Store-side write port lets the loader and data path patch instruction memory one slot at a time.
- Sits between the PC-redirect logic (EX/branch unit) and the decode stage.

Parameters:
- SLOTS, 4, instruction slots per bundle (power of 2, at least 2).
- SLOT_W, 32, bits per slot; bundle width BW = SLOTS*SLOT_W.
- ADDR_W, 14, bundle address width; memory depth is 2**ADDR_W.
- RAS_DEPTH, 8, return-address stack entries (power of 2).
- IMEM_TAG, 5'b11110, value of daddr[29:25] that selects instruction memory for stores.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold fetch state and output bundle.
- flush  in  1  squash the output bundle.
- npc  in  ADDR_W  redirect target.
- npc_en  in  1  redirect valid.
- inst  out  BW  fetched bundle; slot 0 is at [BW-1 -: SLOT_W].
- inst_pc  out  ADDR_W  address of the bundle on inst.
- inst_valid  out  1  inst holds a real bundle.
- ras_empty  out  1  RAS holds no entries.
- dec_op32  in  SLOT_W  store data.
- daddr3  in  30  store word address.
- dec_mwe3  in  1  store enable.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_n=0: inst=0, inst_pc=0, inst_valid=0, pc=0, RAS count=0 and pointer=0, ras_empty=1. Memory contents are not reset.
- Predecode of s0 = slot 0 of the current inst, gated by inst_valid. Let op = s0[2:0] and fn = s0[5:3].
  - jabs: op=111 and {fn[2],fn[0]}=00. Target = s0[6 +: ADDR_W].
  - call (push): op=111 and fn[2:1]=01.
  - ret (pop): s0[5:0]=100111.
- Next fetch address, in priority order:
  - npc_en: read npc, pc <= npc+1.
  - jabs: read target, pc <= target+1.
  - ret and RAS non-empty: read top, pc <= top+1.
  - Otherwise: read pc, pc <= pc+1. PC arithmetic wraps modulo 2**ADDR_W.
- Latency: one cycle. The chosen address appears on inst_pc and its data on inst at the next edge, with inst_valid <= 1.
- stall=1 (and flush=0): pc, inst, inst_pc, inst_valid and the RAS all hold.
- flush=1: overrides stall. inst <= 0 and inst_valid <= 0.
  - If npc_en is also high, pc <= npc; otherwise pc holds.
  - No push or pop in a flush cycle.
- RAS:
  - Push and pop are suppressed when npc_en=1, flush=1 or stall=1.
  - Push writes the current pc, i.e. call address+1.
  - Push when full: overwrites the oldest entry (circular); count stays at RAS_DEPTH.
  - Pop when empty: no-op; fetch falls through sequentially.
  - jabs with call encoding both jumps and pushes.
- Store port:
  - Write condition: daddr3[29:25]=IMEM_TAG and dec_mwe3=1. Writes happen independently of stall and flush.
  - SO = log2(SLOTS). Row = daddr3[SO +: ADDR_W]. Slot k = daddr3[SO-1:0], where k=0 is the MSB slot.
  - Only that slot's SLOT_W bits are written.
  - Same-cycle read and write to the same row returns the old data (read-first).

Decomposition:
- Package ifetch_pkg holds the opcode/funct constants (OP_J=3'b111, RET_CODE=6'b100111), the slot-extraction function and IMEM_TAG.
- One sub-module, ifetch_ras: parametrised circular stack with ports push, pop, din, top, empty, full.
- Memory is inferred inline as block RAM with per-slot byte-lane-style write enables.

Test Plan:
- Reset and sequential fetch: preload rows 0..3; release rst_n -> inst_valid rises one cycle later, inst_pc runs 0,1,2,3 and inst equals mem[0..3].
- Jump: bundle at row 5 has s0 = jabs to 0x40 -> next inst_pc=0x40, then 0x41.
- Call and return: call at row 10 to 0x100; the bundle at 0x100 is a ret -> fetch resumes at 11. Eight nested calls followed by nine rets -> eight correct returns, the ninth falls through and ras_empty=1.
- Redirect versus jump: npc_en=1 with npc=0x200 in the same cycle a jabs is in inst -> inst_pc=0x200 and no RAS change.
- Stall and flush: stall for 3 cycles -> inst and inst_pc constant. Flush with npc_en (npc=0x30) during a stall -> inst=0 and inst_valid=0 next cycle, then inst_pc=0x30.
- Store port: daddr3={5'b11110,...} with row 7, slot 2 and data 0xDEADBEEF, while fetching row 7 in the same cycle -> the current fetch returns the old data; a re-fetch of row 7 shows bits [63:32]=0xDEADBEEF and the other slots unchanged.
